smallmul_serial: RTL and testbench



---
 rtl/smalldiv_pkg.sv | 24 ++
 rtl/smallmul_lut.sv | 25 ++
 rtl/smallmul_serial.sv | 154 +++++++++++++++
 tb/tb_smallmul_serial.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/smalldiv_pkg.sv
// Shared sizing helpers and FSM state type for the small constant divider/multiplier pair.
package smalldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } smallmul_state_t;

  // Digit width: whatever the LUT has left after the carry, but never narrower than the carry.
  function automatic int unsigned smalldiv_digit_width(input int unsigned lut_width,
                                                       input int unsigned divider_width);
    int unsigned base;
    base = (lut_width > divider_width) ? (lut_width - divider_width) : 0;
    return (base > divider_width) ? base : divider_width;
  endfunction

  // Number of digits needed to cover the dividend (ceiling division).
  function automatic int unsigned smalldiv_num_digits(input int unsigned dividend_width,
                                                      input int unsigned digit_width);
    return (dividend_width + digit_width - 1) / digit_width;
  endfunction

endpackage

// File: rtl/smallmul_lut.sv
// One digit step of the serial multiplier: {carry_out, pdigit} = digit * DIVIDER_VALUE + carry_in.
module smallmul_lut #(
  parameter int unsigned DIVIDER_VALUE = 5,
  parameter int unsigned DIVIDER_WIDTH = 3,
  parameter int unsigned DIGIT_WIDTH   = 3
) (
  input  logic [DIGIT_WIDTH-1:0]   digit,
  input  logic [DIVIDER_WIDTH-1:0] carry_in,
  output logic [DIGIT_WIDTH-1:0]   pdigit_c,
  output logic [DIVIDER_WIDTH:0]   carry_out_c
);

  // One extra bit so an out-of-range carry_in never wraps the sum.
  localparam int unsigned SUM_W = DIGIT_WIDTH + DIVIDER_WIDTH + 1;

  logic [SUM_W-1:0] sum;

  // Multiply-accumulate for a single digit, split into digit and carry.
  always_comb begin
    sum         = SUM_W'(digit) * SUM_W'(DIVIDER_VALUE) + SUM_W'(carry_in);
    pdigit_c    = sum[DIGIT_WIDTH-1:0];
    carry_out_c = sum[SUM_W-1:DIGIT_WIDTH];
  end

endmodule

// File: rtl/smallmul_serial.sv
// Digit-serial reconstruction of dividend = quotient * DIVIDER_VALUE + remainder, LSB digit first.
module smallmul_serial
  import smalldiv_pkg::*;
#(
  parameter int unsigned DIVIDER_VALUE         = 5,
  parameter int unsigned DIVIDER_WIDTH         = $clog2(DIVIDER_VALUE),
  parameter int unsigned DIVIDEND_WIDTH        = 18,
  parameter int unsigned THEORETICAL_LUT_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      srst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] quotient,
  input  logic [DIVIDER_WIDTH-1:0]  remainder,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] dividend,
  output logic                      overflow,
  output logic                      rem_error
);

  localparam int unsigned DIGIT_WIDTH  = smalldiv_digit_width(THEORETICAL_LUT_WIDTH, DIVIDER_WIDTH);
  localparam int unsigned NUM_DIGITS   = smalldiv_num_digits(DIVIDEND_WIDTH, DIGIT_WIDTH);
  localparam int unsigned PADDED_WIDTH = NUM_DIGITS * DIGIT_WIDTH;
  localparam int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Reject parameter sets whose carry cannot be represented.
  if (DIVIDER_VALUE <= 1 || $clog2(DIVIDER_VALUE) > DIVIDER_WIDTH) begin : g_param_check
    $fatal(1, "smallmul_serial: DIVIDER_VALUE must be > 1 and fit in DIVIDER_WIDTH bits");
  end

  smallmul_state_t           state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DIVIDER_WIDTH-1:0]  carry_q, carry_d;
  logic [PADDED_WIDTH-1:0]   quot_q, quot_d;
  logic [PADDED_WIDTH-1:0]   product_q, product_d;
  logic                      lost_q, lost_d;
  logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d;
  logic                      overflow_q, overflow_d;
  logic                      rem_error_q, rem_error_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic [DIGIT_WIDTH-1:0]    qdigit;
  logic [DIGIT_WIDTH-1:0]    pdigit_c;
  logic [DIVIDER_WIDTH:0]    carry_out_c;
  logic                      prod_hi;

  // Current quotient digit feeding the LUT.
  assign qdigit = quot_q[idx_q * DIGIT_WIDTH +: DIGIT_WIDTH];

  smallmul_lut #(
    .DIVIDER_VALUE (DIVIDER_VALUE),
    .DIVIDER_WIDTH (DIVIDER_WIDTH),
    .DIGIT_WIDTH   (DIGIT_WIDTH)
  ) u_lut (
    .digit       (qdigit),
    .carry_in    (carry_q),
    .pdigit_c    (pdigit_c),
    .carry_out_c (carry_out_c)
  );

  // Next-state, datapath and registered handshake decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    quot_d      = quot_q;
    product_d   = product_q;
    lost_d      = lost_q;
    dividend_d  = dividend_q;
    overflow_d  = overflow_q;
    rem_error_d = rem_error_q;
    prod_hi     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          quot_d      = PADDED_WIDTH'(quotient);
          carry_d     = remainder;
          rem_error_d = (32'(remainder) >= 32'(DIVIDER_VALUE));
          lost_d      = 1'b0;
          idx_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        product_d[idx_q * DIGIT_WIDTH +: DIGIT_WIDTH] = pdigit_c;
        carry_d = carry_out_c[DIVIDER_WIDTH-1:0];
        // A carry bit beyond the register only arises from an out-of-range remainder.
        lost_d  = lost_q | carry_out_c[DIVIDER_WIDTH];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          for (int b = DIVIDEND_WIDTH; b < PADDED_WIDTH; b++) begin
            prod_hi = prod_hi | product_d[b];
          end
          overflow_d = lost_q | (carry_out_c != '0) | prod_hi;
          dividend_d = product_d[DIVIDEND_WIDTH-1:0];
          idx_d      = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!srst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= '0;
      quot_q      <= '0;
      product_q   <= '0;
      lost_q      <= 1'b0;
      dividend_q  <= '0;
      overflow_q  <= 1'b0;
      rem_error_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      quot_q      <= quot_d;
      product_q   <= product_d;
      lost_q      <= lost_d;
      dividend_q  <= dividend_d;
      overflow_q  <= overflow_d;
      rem_error_q <= rem_error_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dividend  = dividend_q;
  assign overflow  = overflow_q;
  assign rem_error = rem_error_q;

endmodule

// File: tb/tb_smallmul_serial.sv
// Self-checking bench for smallmul_serial (D=5, 18-bit, 3-bit digits, 6 digits).
module tb_smallmul_serial;

  localparam int unsigned D   = 5;
  localparam int unsigned W   = 18;
  localparam int unsigned DW  = 3;
  localparam int unsigned LAT = 6;
  localparam int unsigned II  = 8;

  logic          clock;
  logic          srst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  quotient;
  logic [DW-1:0] remainder;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dividend;
  logic          overflow;
  logic          rem_error;

  int n_checks = 0;
  int n_fail   = 0;

  smallmul_serial #(
    .DIVIDER_VALUE         (D),
    .DIVIDEND_WIDTH        (W),
    .THEORETICAL_LUT_WIDTH (6)
  ) dut (
    .clock     (clock),
    .srst_n    (srst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .overflow  (overflow),
    .rem_error (rem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact arithmetic, then reduce to the output width.
  task automatic model(input longint q, input longint r,
                       output longint dv, output logic ov, output logic re);
    longint t;
    t  = q * longint'(D) + r;
    dv = t % (longint'(1) << W);
    ov = (t >= (longint'(1) << W));
    re = (r >= longint'(D));
  endtask

  // One full operation: accept, latency check, result check, optional backpressure, release.
  task automatic run_op(input string tag, input longint q, input longint r, input int hold);
    longint edv;
    logic   eov, ere;
    int     lat;
    logic [W-1:0] held_dv;
    model(q, r, edv, eov, ere);
    lat = 0;
    while (!in_ready && lat < 50) begin tick(); lat++; end
    chk({tag, "/ready_before"}, 64'(in_ready), 64'd1);
    quotient  = W'(q);
    remainder = DW'(r);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk({tag, "/busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk({tag, "/latency"}, 64'(lat), 64'(LAT));
    chk({tag, "/dividend"}, 64'(dividend), 64'(edv));
    chk({tag, "/overflow"}, 64'(overflow), 64'(eov));
    chk({tag, "/rem_error"}, 64'(rem_error), 64'(ere));
    held_dv = dividend;
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      quotient  = ~quotient;
      remainder = DW'(i);
      tick();
      chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "/hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "/hold_dividend"}, 64'(dividend), 64'(edv));
      chk({tag, "/hold_overflow"}, 64'(overflow), 64'(eov));
      chk({tag, "/hold_rem_error"}, 64'(rem_error), 64'(ere));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/release_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "/release_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "/release_dividend"}, 64'(dividend), 64'(held_dv));
  endtask

  longint x, q, r, edv;
  logic   eov, ere;
  longint exp_dv[$];
  logic   exp_ov[$];
  logic   exp_re[$];
  int     nacc, nres, last_res, budget;
  logic   acc, res;

  initial begin
    srst_n    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    quotient  = '0;
    remainder = '0;
    tick();
    tick();
    srst_n = 1'b1;
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/dividend", 64'(dividend), 64'd0);
    chk("reset/overflow", 64'(overflow), 64'd0);
    chk("reset/rem_error", 64'(rem_error), 64'd0);

    // Directed cases
    run_op("t12345", 12345, 3, 0);
    run_op("t52429", 52429, 0, 0);
    run_op("rem5", 0, 5, 0);
    run_op("qmax_r7", 262143, 7, 0);
    run_op("zero", 0, 0, 0);

    // Round trip through a behavioural divider with backpressure
    for (int k = 0; k < 4; k++) begin
      x = longint'($urandom_range(0, 262143));
      run_op("roundtrip", x / D, x % D, 4);
    end

    // Random operands, including out-of-range remainders
    for (int k = 0; k < 6; k++) begin
      run_op("random", longint'($urandom_range(0, 262143)), longint'($urandom_range(0, 7)), k % 3);
    end

    // Reset in the middle of RUN (digit index 3)
    quotient  = W'(1000);
    remainder = DW'(2);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
    tick();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    chk("midreset/out_valid", 64'(out_valid), 64'd0);
    chk("midreset/in_ready", 64'(in_ready), 64'd1);
    chk("midreset/dividend", 64'(dividend), 64'd0);
    chk("midreset/overflow", 64'(overflow), 64'd0);
    chk("midreset/rem_error", 64'(rem_error), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midreset/no_result", 64'(out_valid), 64'd0);
    end
    run_op("after_reset", 4321, 4, 0);

    // Back-to-back with in_valid held and out_ready held
    nacc      = 0;
    nres      = 0;
    last_res  = -1;
    quotient  = W'($urandom_range(0, 262143));
    remainder = DW'($urandom_range(0, 7));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 90; c++) begin
      acc = in_valid && in_ready;
      res = out_valid && out_ready;
      if (res) begin
        chk("b2b/queue_nonempty", 64'(exp_dv.size() > 0), 64'd1);
        if (exp_dv.size() > 0) begin
          chk("b2b/dividend", 64'(dividend), 64'(exp_dv.pop_front()));
          chk("b2b/overflow", 64'(overflow), 64'(exp_ov.pop_front()));
          chk("b2b/rem_error", 64'(rem_error), 64'(exp_re.pop_front()));
        end
        if (last_res >= 0) chk("b2b/interval", 64'(c - last_res), 64'(II));
        last_res = c;
        nres++;
      end
      if (acc) begin
        model(longint'(quotient), longint'(remainder), edv, eov, ere);
        exp_dv.push_back(edv);
        exp_ov.push_back(eov);
        exp_re.push_back(ere);
        nacc++;
      end
      tick();
      if (acc) begin
        quotient  = W'($urandom_range(0, 262143));
        remainder = DW'($urandom_range(0, 7));
      end
    end
    in_valid = 1'b0;
    budget   = 0;
    while (exp_dv.size() > 0 && budget < 40) begin
      if (out_valid) begin
        chk("b2b/drain_dividend", 64'(dividend), 64'(exp_dv.pop_front()));
        chk("b2b/drain_overflow", 64'(overflow), 64'(exp_ov.pop_front()));
        chk("b2b/drain_rem_error", 64'(rem_error), 64'(exp_re.pop_front()));
        nres++;
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    chk("b2b/all_drained", 64'(exp_dv.size()), 64'd0);
    chk("b2b/count_match", 64'(nres), 64'(nacc));
    chk("b2b/enough_results", 64'(nres >= 10), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
